// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: default sizing and FSM state encoding.
package mem_arb_pkg;

    localparam int NREQ_DEF       = 4;
    localparam int WIDTH_DEF      = 5;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int TIMEOUT_DEF    = 8;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; master = arbiter view, slave = environment view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic [NREQ-1:0]            req_i;
    logic [NREQ-1:0]            req_wr_rd_i;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NREQ*WIDTH-1:0]      req_wdata_i;

    logic [NREQ-1:0]            gnt_o;
    logic [NREQ-1:0]            done_o;
    logic [WIDTH-1:0]           rd_data_o;
    logic                       err_o;

    logic                       mem_valid_o;
    logic                       mem_wr_rd_o;
    logic [ADDR_WIDTH-1:0]      mem_addr_o;
    logic [WIDTH-1:0]           mem_wdata_o;
    logic                       mem_ready_i;
    logic [WIDTH-1:0]           mem_rdata_i;

    modport master (
        input  req_i, req_wr_rd_i, req_addr_i, req_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output gnt_o, done_o, rd_data_o, err_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output req_i, req_wr_rd_i, req_addr_i, req_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  gnt_o, done_o, rd_data_o, err_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin winner search: first set request at or above ptr, else lowest set request.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             any_req
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;

    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NREQ; k++) begin
            hi_mask[k] = (PTR_W'(k) >= ptr);
        end
        req_hi  = req & hi_mask;
        any_req = |req;
        // x & -x isolates the lowest set bit; the unmasked fallback gives the wrap to 0.
        if (|req_hi) begin
            winner = req_hi & (~req_hi + NREQ'(1));
        end else begin
            winner = req & (~req + NREQ'(1));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one requester at a time a single access to a shared memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("mem_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be 1..255");
    end

    state_t                state;
    state_t                state_nxt;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      win_idx;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  timeout_hit;

    logic [NREQ-1:0]       pick_oh;
    logic                  any_req;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [PTR_W-1:0]      sel_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        if (idx == PTR_W'(NREQ - 1)) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (bus.req_i),
        .ptr     (ptr),
        .winner  (pick_oh),
        .any_req (any_req)
    );

    // Steer the winner's request fields through a one-hot mux.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_oh[k]) begin
                sel_wr    = bus.req_wr_rd_i[k];
                sel_addr  = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata_i[k*WIDTH +: WIDTH];
                sel_idx   = PTR_W'(k);
            end
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.mem_ready_i || timeout_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs; the mem_* fields double as the latched request and hold between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr             <= '0;
            win_idx         <= '0;
            wait_cnt        <= '0;
            bus.gnt_o       <= '0;
            bus.done_o      <= '0;
            bus.err_o       <= 1'b0;
            bus.rd_data_o   <= '0;
            bus.mem_valid_o <= 1'b0;
            bus.mem_wr_rd_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            bus.done_o      <= '0;
            bus.mem_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        bus.gnt_o       <= pick_oh;
                        win_idx         <= sel_idx;
                        bus.mem_valid_o <= 1'b1;
                        bus.mem_wr_rd_o <= sel_wr;
                        bus.mem_addr_o  <= sel_addr;
                        bus.mem_wdata_o <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (bus.mem_ready_i) begin
                        if (!bus.mem_wr_rd_o) begin
                            bus.rd_data_o <= bus.mem_rdata_i;
                        end
                        bus.err_o  <= 1'b0;
                        bus.done_o <= bus.gnt_o;
                    end else if (timeout_hit) begin
                        bus.err_o  <= 1'b1;
                        bus.done_o <= bus.gnt_o;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.gnt_o <= '0;
                    ptr       <= next_ptr(win_idx);
                end
                default: begin
                    bus.gnt_o <= '0;
                end
            endcase
        end
    end

endmodule
